fifo_flag_servicer: RTL and testbench

- Consumer and clear-issuer for the sticky FIFO flags wr_overflow and rd_underflow.
- Synchronises both flags into one control clock and counts each new assertion in a saturating counter.
- Drives wr_clear/rd_clear back to the flag generator using a level-held clear handshake: clear is held until the flag is seen low.
- Sits between the FIFO flag logic and the host status/register interface.

---
 rtl/fifo_flag_servicer.sv | 233 +++++++++++++++++++++++
 tb/tb_fifo_flag_servicer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flag_servicer.sv
// -----------------------------------------------------------------------------
// fifo_flag_servicer
//
// Consumes the sticky FIFO flags wr_overflow / rd_underflow, counts each new
// assertion, and runs a level-held clear handshake back to the flag generator:
// the clear request stays high until the synchronised flag is seen low, or
// until CLR_TIMEOUT+1 cycles elapse, whichever comes first.
//
// Parameters:
//   CNT_WIDTH    width of each saturating event counter
//   SYNC_STAGES  synchroniser depth on each incoming flag (>= 2)
//   CLR_TIMEOUT  last timer value before a clear handshake is abandoned (1..255)
//
// Ports:
//   clk              control clock, rising edge
//   reset_n          asynchronous active-low reset
//   wr_overflow_in   sticky overflow flag (asynchronous)
//   rd_underflow_in  sticky underflow flag (asynchronous)
//   auto_clear       level: clear each flag as soon as it has been counted
//   host_clear       one-cycle pulse: zero counts/error, clear pending flags
//   wr_clear         clear request to the overflow flag logic
//   rd_clear         clear request to the underflow flag logic
//   ovf_count        overflow event count (saturating)
//   unf_count        underflow event count (saturating)
//   ovf_pending      overflow counted, not yet cleared
//   unf_pending      underflow counted, not yet cleared
//   clr_timeout_err  sticky: a clear handshake timed out on either channel
//   irq              (only with FIFO_FLAG_IRQ_EN) one-cycle pulse on any new
//                    detection or any timeout
//
// Optional build macro: FIFO_FLAG_IRQ_EN adds the irq output.
//
// Channel FSM (one instance per flag):
//   state        | meaning
//   -------------+----------------------------------------------------------
//   ST_IDLE      | flag not seen; waiting for the synced flag to rise
//   ST_DETECTED  | event counted, pending=1; waiting for auto/host clear
//   ST_CLEARING  | clear held high, timer running; waiting for flag to drop
// -----------------------------------------------------------------------------
module fifo_flag_servicer #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CLR_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_overflow_in,
  input  logic                 rd_underflow_in,
  input  logic                 auto_clear,
  input  logic                 host_clear,
  output logic                 wr_clear,
  output logic                 rd_clear,
  output logic [CNT_WIDTH-1:0] ovf_count,
  output logic [CNT_WIDTH-1:0] unf_count,
  output logic                 ovf_pending,
  output logic                 unf_pending,
  output logic                 clr_timeout_err
`ifdef FIFO_FLAG_IRQ_EN
  ,
  output logic                 irq
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DETECTED = 2'd1,
    ST_CLEARING = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [7:0]           TO_VAL  = 8'(CLR_TIMEOUT);

  // Channel 0 = overflow / wr_clear, channel 1 = underflow / rd_clear.
  logic [1:0]           w_flag_in;
  logic [1:0]           w_event;
  logic [1:0]           w_timeout;
  logic [1:0]           w_clear;
  logic [1:0]           w_pending;
  logic [CNT_WIDTH-1:0] w_cnt [2];

  assign w_flag_in = {rd_underflow_in, wr_overflow_in};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s_flag;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_timer;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   w_ev;
    logic                   w_to;
    logic                   w_clr;
    logic                   w_pend;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_flag_in[g]};
      end
    end

    assign w_s_flag = r_sync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    // Next-state logic; event and timeout strobes are decoded here so they
    // line up exactly with the transitions that define them.
    always_comb begin
      w_state_nxt = r_state;
      w_ev        = 1'b0;
      w_to        = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s_flag) begin
            w_ev        = 1'b1;
            w_state_nxt = ST_DETECTED;
          end
        end
        ST_DETECTED: begin
          if (auto_clear || host_clear) begin
            w_state_nxt = ST_CLEARING;
          end
        end
        ST_CLEARING: begin
          // A dropped flag beats a coincident timeout.
          if (!w_s_flag) begin
            w_state_nxt = ST_IDLE;
          end else if (r_timer == TO_VAL) begin
            w_to        = 1'b1;
            w_state_nxt = ST_DETECTED;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    // Output decode
    always_comb begin
      w_clr  = 1'b0;
      w_pend = 1'b0;
      case (r_state)
        ST_DETECTED: begin
          w_pend = 1'b1;
        end
        ST_CLEARING: begin
          w_clr  = 1'b1;
          w_pend = 1'b1;
        end
        default: begin
          w_clr  = 1'b0;
          w_pend = 1'b0;
        end
      endcase
    end

    // Timer is 0 on the first CLEARING cycle; host_clear does not restart it.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_timer <= '0;
      end else if ((r_state == ST_CLEARING) && (w_state_nxt == ST_CLEARING)) begin
        r_timer <= r_timer + 8'd1;
      end else begin
        r_timer <= '0;
      end
    end

    // host_clear zeroes the count, but an event in the same cycle survives
    // as a count of one.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (host_clear) begin
        r_cnt <= w_ev ? CNT_ONE : '0;
      end else if (w_ev && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end

    assign w_event[g]   = w_ev;
    assign w_timeout[g] = w_to;
    assign w_clear[g]   = w_clr;
    assign w_pending[g] = w_pend;
    assign w_cnt[g]     = r_cnt;
  end

  // Shared sticky error; a timeout in the same cycle as host_clear wins.
  logic r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (|w_timeout) begin
      r_err <= 1'b1;
    end else if (host_clear) begin
      r_err <= 1'b0;
    end
  end

`ifdef FIFO_FLAG_IRQ_EN
  // Single registered pulse even when both channels fire together.
  logic r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (|w_event) || (|w_timeout);
    end
  end

  assign irq = r_irq;
`endif

  assign wr_clear        = w_clear[0];
  assign rd_clear        = w_clear[1];
  assign ovf_pending     = w_pending[0];
  assign unf_pending     = w_pending[1];
  assign ovf_count       = w_cnt[0];
  assign unf_count       = w_cnt[1];
  assign clr_timeout_err = r_err;

endmodule

// File: tb/tb_fifo_flag_servicer.sv
// Scoreboard bench for fifo_flag_servicer (CNT_WIDTH=4, SYNC_STAGES=2,
// CLR_TIMEOUT=15). Expected values are queued with the cycle they are due
// when stimulus is applied, and compared on the falling edge of that cycle.
module tb_fifo_flag_servicer;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_overflow_in = 1'b0;
  logic          rd_underflow_in = 1'b0;
  logic          auto_clear = 1'b0;
  logic          host_clear = 1'b0;
  logic          wr_clear, rd_clear, ovf_pending, unf_pending, clr_timeout_err;
  logic [CW-1:0] ovf_count, unf_count;
`ifdef FIFO_FLAG_IRQ_EN
  logic          irq;
`endif

  fifo_flag_servicer #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(2),
    .CLR_TIMEOUT(15)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_overflow_in (wr_overflow_in),
    .rd_underflow_in(rd_underflow_in),
    .auto_clear     (auto_clear),
    .host_clear     (host_clear),
    .wr_clear       (wr_clear),
    .rd_clear       (rd_clear),
    .ovf_count      (ovf_count),
    .unf_count      (unf_count),
    .ovf_pending    (ovf_pending),
    .unf_pending    (unf_pending),
    .clr_timeout_err(clr_timeout_err)
`ifdef FIFO_FLAG_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  typedef enum int {F_WCLR, F_RCLR, F_OCNT, F_UCNT, F_OPEND, F_UPEND, F_ERR, F_IRQ} field_e;
  typedef struct {
    string  tag;
    int     at;
    field_e f;
    int     val;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] peek(input field_e f);
    logic [31:0] v;
    v = '0;
    case (f)
      F_WCLR:  v = {31'd0, wr_clear};
      F_RCLR:  v = {31'd0, rd_clear};
      F_OCNT:  v = {28'd0, ovf_count};
      F_UCNT:  v = {28'd0, unf_count};
      F_OPEND: v = {31'd0, ovf_pending};
      F_UPEND: v = {31'd0, unf_pending};
      F_ERR:   v = {31'd0, clr_timeout_err};
`ifdef FIFO_FLAG_IRQ_EN
      F_IRQ:   v = {31'd0, irq};
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic expect_at(input string tag, input field_e f, input int dc, input int v);
    exp_t e;
    e.tag = tag;
    e.at  = cyc + dc;
    e.f   = f;
    e.val = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        chk(sb[i].tag, peek(sb[i].f), 32'(sb[i].val));
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_ovf;

  initial begin
    // Reset state
    step(3);
    chk("rst_wclr", {31'd0, wr_clear}, 0);
    chk("rst_rclr", {31'd0, rd_clear}, 0);
    chk("rst_ocnt", {28'd0, ovf_count}, 0);
    chk("rst_ucnt", {28'd0, unf_count}, 0);
    chk("rst_opend", {31'd0, ovf_pending}, 0);
    chk("rst_upend", {31'd0, unf_pending}, 0);
    chk("rst_err", {31'd0, clr_timeout_err}, 0);
`ifdef FIFO_FLAG_IRQ_EN
    chk("rst_irq", {31'd0, irq}, 0);
`endif
    reset_n = 1'b1;
    step(2);

    // Auto-clear handshake with flag dropping in time
    auto_clear = 1'b1;
    wr_overflow_in = 1'b1;
    expect_at("t1_ocnt", F_OCNT, 3, 1);
    expect_at("t1_opend", F_OPEND, 3, 1);
    expect_at("t1_wclr_pre", F_WCLR, 3, 0);
    expect_at("t1_wclr", F_WCLR, 4, 1);
`ifdef FIFO_FLAG_IRQ_EN
    expect_at("t1_irq", F_IRQ, 3, 1);
    expect_at("t1_irq_end", F_IRQ, 4, 0);
`endif
    step(8);
    wr_overflow_in = 1'b0;
    expect_at("t1_wclr_hold", F_WCLR, 2, 1);
    expect_at("t1_wclr_drop", F_WCLR, 3, 0);
    expect_at("t1_opend_drop", F_OPEND, 3, 0);
    expect_at("t1_ocnt_keep", F_OCNT, 3, 1);
    step(6);

    // Manual mode: flag held, no clear until host_clear
    auto_clear = 1'b0;
    rd_underflow_in = 1'b1;
    expect_at("t2_ucnt", F_UCNT, 3, 1);
    expect_at("t2_upend", F_UPEND, 3, 1);
    expect_at("t2_rclr_a", F_RCLR, 3, 0);
    expect_at("t2_rclr_b", F_RCLR, 25, 0);
    expect_at("t2_rclr_c", F_RCLR, 49, 0);
    expect_at("t2_ucnt_held", F_UCNT, 49, 1);
    step(50);
    host_clear = 1'b1;
    expect_at("t2_ucnt_hc", F_UCNT, 1, 0);
    expect_at("t2_ocnt_hc", F_OCNT, 1, 0);
    expect_at("t2_rclr_hc", F_RCLR, 1, 1);
    expect_at("t2_upend_hc", F_UPEND, 1, 1);
    expect_at("t2_wclr_hc", F_WCLR, 1, 0);
    step(1);
    host_clear = 1'b0;
    rd_underflow_in = 1'b0;
    expect_at("t2_rclr_hold", F_RCLR, 2, 1);
    expect_at("t2_rclr_drop", F_RCLR, 3, 0);
    expect_at("t2_upend_drop", F_UPEND, 3, 0);
    step(6);

    // Stuck flag: clear held 16 cycles then timeout
    auto_clear = 1'b1;
    wr_overflow_in = 1'b1;
    expect_at("t3_ocnt", F_OCNT, 3, 1);
    expect_at("t3_wclr_pre", F_WCLR, 3, 0);
    expect_at("t3_wclr_first", F_WCLR, 4, 1);
    expect_at("t3_wclr_last", F_WCLR, 19, 1);
    expect_at("t3_err_pre", F_ERR, 19, 0);
    expect_at("t3_wclr_to", F_WCLR, 20, 0);
    expect_at("t3_err", F_ERR, 20, 1);
    expect_at("t3_opend", F_OPEND, 20, 1);
    expect_at("t3_ocnt_to", F_OCNT, 20, 1);
`ifdef FIFO_FLAG_IRQ_EN
    expect_at("t3_irq_pre", F_IRQ, 19, 0);
    expect_at("t3_irq_to", F_IRQ, 20, 1);
`endif
    step(20);
    wr_overflow_in = 1'b0;
    expect_at("t3_wclr_retry", F_WCLR, 1, 1);
    expect_at("t3_wclr_done", F_WCLR, 3, 0);
    expect_at("t3_opend_done", F_OPEND, 3, 0);
    expect_at("t3_err_sticky", F_ERR, 3, 1);
    step(6);

    // 20 cleared overflow pulses: 4-bit count saturates at 15
    exp_ovf = 1;
    for (int k = 0; k < 20; k++) begin
      wr_overflow_in = 1'b1;
      exp_ovf = (exp_ovf == 15) ? 15 : exp_ovf + 1;
      expect_at($sformatf("t4_ocnt_%0d", k), F_OCNT, 3, exp_ovf);
      expect_at($sformatf("t4_opend_set_%0d", k), F_OPEND, 3, 1);
      expect_at($sformatf("t4_opend_clr_%0d", k), F_OPEND, 8, 0);
      step(5);
      wr_overflow_in = 1'b0;
      step(5);
    end
    expect_at("t4_ocnt_sat", F_OCNT, 1, 15);
    expect_at("t4_err_keep", F_ERR, 1, 1);
    step(2);

    // host_clear coincident with a new underflow detection
    auto_clear = 1'b0;
    rd_underflow_in = 1'b1;
    step(2);
    host_clear = 1'b1;
    expect_at("t5_err_pre", F_ERR, 0, 1);
    expect_at("t5_ucnt", F_UCNT, 1, 1);
    expect_at("t5_upend", F_UPEND, 1, 1);
    expect_at("t5_rclr", F_RCLR, 1, 0);
    expect_at("t5_ocnt", F_OCNT, 1, 0);
    expect_at("t5_opend", F_OPEND, 1, 0);
    expect_at("t5_wclr", F_WCLR, 1, 0);
    expect_at("t5_err", F_ERR, 1, 0);
`ifdef FIFO_FLAG_IRQ_EN
    expect_at("t5_irq", F_IRQ, 1, 1);
`endif
    step(1);
    host_clear = 1'b0;
    expect_at("t5_rclr_stay", F_RCLR, 2, 0);
    step(4);

    // Asynchronous reset in the middle of a clear handshake
    host_clear = 1'b1;
    expect_at("t6_rclr", F_RCLR, 1, 1);
    expect_at("t6_ucnt", F_UCNT, 1, 0);
    step(1);
    host_clear = 1'b0;
    expect_at("t6_rclr_hold", F_RCLR, 1, 1);
    step(2);
    #2;
    chk("t6_rclr_before", {31'd0, rd_clear}, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rclr_async", {31'd0, rd_clear}, 0);
    chk("t6_upend_async", {31'd0, unf_pending}, 0);
    chk("t6_ucnt_async", {28'd0, unf_count}, 0);
    chk("t6_ocnt_async", {28'd0, ovf_count}, 0);
    chk("t6_err_async", {31'd0, clr_timeout_err}, 0);
    step(3);
    rd_underflow_in = 1'b0;
    reset_n = 1'b1;
    step(2);

    // Both channels detect in the same cycle
    auto_clear = 1'b0;
    wr_overflow_in = 1'b1;
    rd_underflow_in = 1'b1;
    expect_at("t7_ocnt", F_OCNT, 3, 1);
    expect_at("t7_ucnt", F_UCNT, 3, 1);
    expect_at("t7_opend", F_OPEND, 3, 1);
    expect_at("t7_upend", F_UPEND, 3, 1);
`ifdef FIFO_FLAG_IRQ_EN
    expect_at("t7_irq_pre", F_IRQ, 2, 0);
    expect_at("t7_irq", F_IRQ, 3, 1);
    expect_at("t7_irq_end", F_IRQ, 4, 0);
    expect_at("t7_irq_quiet", F_IRQ, 6, 0);
`endif
    step(8);
    wr_overflow_in = 1'b0;
    rd_underflow_in = 1'b0;

    for (int w = 0; w < 200 && sb.size() > 0; w++) step(1);
    while (sb.size() > 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: never compared, due at cycle %0d (now %0d)", sb[0].tag, sb[0].at, cyc);
      sb.delete(0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
